// File: rtl/design_reset_sequencer_if.sv
// Select-request handshake between the config register file (master)
// and the reset sequencer (slave).
interface design_reset_sequencer_if #(
    parameter int ID_W = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [ID_W-1:0] req_id;

    modport master (
        output req_valid,
        output req_id,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_id,
        output req_ready
    );
endinterface

// File: rtl/design_reset_sequencer.sv
// Reset sequencer for the user designs: isolates all designs, releases the selected
// one, waits out the downstream synchronizer latency, then enables its IOs.
module design_reset_sequencer #(
    parameter int NUM_DESIGNS = 12,
    parameter int ID_W        = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int SYNC_LAT    = 2,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       asyncrst_n,
    design_reset_sequencer_if.slave    req_if,
    input  logic                       soft_rst,
    output logic [NUM_DESIGNS-1:0]     designs_cs,
    output logic [NUM_DESIGNS-1:0]     design_en,
    output logic [ID_W-1:0]            active_id,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISOLATE = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [ID_W-1:0]  MAX_ID    = ID_W'(NUM_DESIGNS);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYNC_LOAD = CNT_W'(SYNC_LAT);

    function automatic logic [NUM_DESIGNS-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_DESIGNS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_DESIGNS; i++) begin
            oh[i] = (id == ID_W'(i + 1));
        end
        return oh;
    endfunction

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [ID_W-1:0]        tgt_q, tgt_d;
    logic [NUM_DESIGNS-1:0] designs_cs_q, designs_cs_d;
    logic [NUM_DESIGNS-1:0] design_en_q, design_en_d;
    logic [ID_W-1:0]        active_id_q, active_id_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   start_s;
    logic [ID_W-1:0]        start_id_s;

    // Start decode: a request always beats a same-cycle soft reset.
    always_comb begin
        start_s    = 1'b0;
        start_id_s = '0;
        err_d      = 1'b0;
        if (req_if.req_valid && (state_q == ST_IDLE)) begin
            if (req_if.req_id > MAX_ID) begin
                err_d = 1'b1;
            end else begin
                start_s    = 1'b1;
                start_id_s = req_if.req_id;
            end
        end else if (soft_rst && (state_q == ST_IDLE) && (active_id_q != '0)) begin
            start_s    = 1'b1;
            start_id_s = active_id_q;
        end else begin
            start_s = 1'b0;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        tgt_d        = tgt_q;
        designs_cs_d = designs_cs_q;
        design_en_d  = design_en_q;
        active_id_d  = active_id_q;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d      = ST_ISOLATE;
                    timer_d      = HOLD_LOAD;
                    tgt_d        = start_id_s;
                    designs_cs_d = '1;
                    design_en_d  = '0;
                    active_id_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISOLATE: begin
                if (timer_q == '0) begin
                    if (tgt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_RELEASE;
                        timer_d      = SYNC_LOAD;
                        designs_cs_d = ~id_onehot(tgt_q);
                    end
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                // Stay here SYNC_LAT+1 cycles so the synchronizer output is settled before IO enable.
                if (timer_q == '0) begin
                    state_d     = ST_IDLE;
                    design_en_d = id_onehot(tgt_q);
                    active_id_d = tgt_q;
                    done_d      = 1'b1;
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                timer_d      = '0;
                designs_cs_d = '1;
                design_en_d  = '0;
                active_id_d  = '0;
            end
        endcase
    end

    // State and output registers; reset puts every design in reset.
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            tgt_q        <= '0;
            designs_cs_q <= '1;
            design_en_q  <= '0;
            active_id_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            tgt_q        <= tgt_d;
            designs_cs_q <= designs_cs_d;
            design_en_q  <= design_en_d;
            active_id_q  <= active_id_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign req_if.req_ready = (state_q == ST_IDLE);
    assign busy             = (state_q != ST_IDLE);
    assign designs_cs       = designs_cs_q;
    assign design_en        = design_en_q;
    assign active_id        = active_id_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule
